slon_rx_checker: RTL and testbench



---
 rtl/slon_rx_pkg.sv | 17 +
 rtl/slon_rx_checker_edge_det.sv | 22 ++
 rtl/slon_rx_checker.sv | 139 +++++++++++++
 tb/tb_slon_rx_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/slon_rx_pkg.sv
// Shared types and default constants for the slon receive-side checker.
package slon_rx_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } RxState_t;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_LOCK_CNT      = 4;
  localparam int DEF_UNLOCK_CNT    = 2;
  localparam int DEF_ERR_CNT_WIDTH = 16;
  localparam int DEF_CLK_FACTOR    = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] Data_t;

endpackage

// File: rtl/slon_rx_checker_edge_det.sv
// slon_edge_det: registered rise/fall detector. The history register resets
// to 0, so a fall can only be reported after the input has been seen high.
module slon_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  // One-cycle history of the sampled input
  always_ff @(posedge clk) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/slon_rx_checker.sv
// slon_rx_checker: recovers one word per in_clk period (captured on the
// in_clk fall, mid-eye) and checks the incrementing test pattern, with a
// HUNT/LOCK state machine and a saturating error counter.
// Optional build macro: SLON_RX_PERIOD_CHECK_EN adds a clk-cycles-per-period
// monitor driving the sticky period_err flag; otherwise period_err is 0.
module slon_rx_checker
  import slon_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LOCK_CNT      = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT    = DEF_UNLOCK_CNT,
  parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH,
  parameter int CLK_FACTOR    = DEF_CLK_FACTOR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_clk,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     locked,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     period_err
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  RxState_t              state;
  logic [DATA_WIDTH-1:0] prev;
  logic                  have_prev;
  logic [GW-1:0]         good_run;
  logic [BW-1:0]         bad_run;

  logic                  fall;
  logic                  unused_rise;
  logic [DATA_WIDTH-1:0] expected;
  logic                  good;
  logic                  bad;
  logic [GW-1:0]         good_next;
  logic [BW-1:0]         bad_next;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  slon_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (in_clk),
    .rise (unused_rise),
    .fall (fall)
  );

  // The first word after reset only seeds prev; it is neither good nor bad.
  assign expected  = prev + DATA_WIDTH'(1);
  assign good      = have_prev && (din == expected);
  assign bad       = have_prev && (din != expected);
  assign good_next = good_run + GW'(1);
  assign bad_next  = bad_run + BW'(1);

  // Capture, pattern check and HUNT/LOCK state machine, all on the in_clk fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      locked    <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
      err_cnt   <= '0;
      have_prev <= 1'b0;
      prev      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= fall;
      if (fall) begin
        out_data  <= din;
        prev      <= din;
        have_prev <= 1'b1;
        case (state)
          HUNT: begin
            if (good) begin
              if (good_next == GW'(LOCK_CNT)) begin
                state    <= LOCK;
                locked   <= 1'b1;
                bad_run  <= '0;
                good_run <= '0;
              end else begin
                good_run <= good_next;
              end
            end else if (bad) begin
              good_run <= '0;
            end
          end
          LOCK: begin
            if (bad) begin
              err_cnt <= sat_inc(err_cnt);
              if (bad_next == BW'(UNLOCK_CNT)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_run <= '0;
                bad_run  <= '0;
              end else begin
                bad_run <= bad_next;
              end
            end else if (good) begin
              bad_run <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef SLON_RX_PERIOD_CHECK_EN
  localparam int PW = $clog2(2 * CLK_FACTOR + 1);

  logic [PW-1:0] period_cnt;

  // Count clk cycles between falls (saturating); flag any period != CLK_FACTOR
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      period_err <= 1'b0;
    end else if (fall) begin
      period_cnt <= PW'(1);
      if (have_prev && (period_cnt != PW'(CLK_FACTOR))) period_err <= 1'b1;
    end else if (period_cnt != PW'(2 * CLK_FACTOR)) begin
      period_cnt <= period_cnt + PW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (CLK_FACTOR != 0);
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_slon_rx_checker.sv
// Scoreboard bench for slon_rx_checker: stimulus pushes hand-computed
// expected words into a queue, a negedge monitor pops and compares on each
// out_valid pulse. A second instance exercises error-counter saturation.
module tb_slon_rx_checker;

  typedef struct {
    logic [7:0]  data;
    logic        lk;
    logic [15:0] err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_clk = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        locked;
  logic [15:0] err_cnt;
  logic        period_err;

  logic        in_clk1 = 1'b0;
  logic [7:0]  din1 = 8'h00;
  logic        out_valid1;
  logic [7:0]  out_data1;
  logic        locked1;
  logic [7:0]  err_cnt1;
  logic        period_err1;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic prev_valid = 1'b0;
  logic exp_pe;

  always #5 clk = ~clk;

  slon_rx_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_clk     (in_clk),
    .din        (din),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .locked     (locked),
    .err_cnt    (err_cnt),
    .period_err (period_err)
  );

  slon_rx_checker #(
    .UNLOCK_CNT    (1000),
    .ERR_CNT_WIDTH (8)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .in_clk     (in_clk1),
    .din        (din1),
    .out_valid  (out_valid1),
    .out_data   (out_data1),
    .locked     (locked1),
    .err_cnt    (err_cnt1),
    .period_err (period_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One strobe period: rise with new data, high for hi cycles, low for 4.
  task automatic drive(input bit sel, input logic [7:0] d, input int hi);
    @(posedge clk); #1;
    if (sel) begin din1 = d; in_clk1 = 1'b1; end
    else     begin din  = d; in_clk  = 1'b1; end
    repeat (hi) @(posedge clk);
    #1;
    if (sel) in_clk1 = 1'b0;
    else     in_clk  = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic w0(input logic [7:0] d, input logic lk, input logic [15:0] e);
    exp_t x;
    x.data = d; x.lk = lk; x.err = e;
    q.push_back(x);
    drive(1'b0, d, 4);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the next queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        exp_t x;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL pulse_width out_valid high two cycles in a row");
        end
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word data=%0h locked=%0b err=%0d", out_data, locked, err_cnt);
        end else begin
          x = q.pop_front();
          if (out_data !== x.data || locked !== x.lk || err_cnt !== x.err) begin
            errors++;
            $display("FAIL word data=%0h/%0h locked=%0b/%0b err=%0d/%0d (actual/expected)",
                     out_data, x.data, locked, x.lk, err_cnt, x.err);
          end
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
`ifdef SLON_RX_PERIOD_CHECK_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_out_data", {24'd0, out_data}, 0);
    chk("reset_locked", {31'd0, locked}, 0);
    chk("reset_err_cnt", {16'd0, err_cnt}, 0);
    chk("reset_period_err", {31'd0, period_err}, 0);

    // Clean stream from 0x00 through the wrap; lock on word 0x04
    for (int i = 0; i < 256; i++) w0(i[7:0], (i >= 4), 16'd0);
    w0(8'h00, 1'b1, 16'd0);
    w0(8'h01, 1'b1, 16'd0);

    // Locked stream with 0x20 corrupted to 0x55
    for (int i = 2; i < 32; i++) w0(i[7:0], 1'b1, 16'd0);
    w0(8'h55, 1'b1, 16'd1);
    w0(8'h21, 1'b0, 16'd2);
    w0(8'h22, 1'b0, 16'd2);
    w0(8'h23, 1'b0, 16'd2);
    w0(8'h24, 1'b0, 16'd2);
    w0(8'h25, 1'b1, 16'd2);
    w0(8'h26, 1'b1, 16'd2);
    chk("pre_rst_locked", {31'd0, locked}, 1);
    chk("pre_rst_err_cnt", {16'd0, err_cnt}, 2);
    chk("period_err_clean", {31'd0, period_err}, 0);

    // Reset while locked with in_clk low: everything clears, no spurious word
    pulse_rst();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 0);
    repeat (10) @(posedge clk);

    // Bad word while hunting: no error count, lock delayed
    w0(8'h10, 1'b0, 16'd0);
    w0(8'h11, 1'b0, 16'd0);
    w0(8'h12, 1'b0, 16'd0);
    w0(8'h40, 1'b0, 16'd0);
    w0(8'h41, 1'b0, 16'd0);
    w0(8'h42, 1'b0, 16'd0);
    w0(8'h43, 1'b0, 16'd0);
    w0(8'h44, 1'b1, 16'd0);
    chk("period_err_before_stretch", {31'd0, period_err}, 0);

    // One stretched period (9 cycles fall-to-fall)
    q.push_back('{data: 8'h45, lk: 1'b1, err: 16'd0});
    drive(1'b0, 8'h45, 5);
    chk("period_err_after_stretch", {31'd0, period_err}, {31'd0, exp_pe});
    w0(8'h46, 1'b1, 16'd0);
    chk("period_err_sticky", {31'd0, period_err}, {31'd0, exp_pe});

    // Saturation on the 8-bit counter instance: lock, then every word bad
    for (int i = 0; i < 5; i++) drive(1'b1, i[7:0], 4);
    chk("sat_locked", {31'd0, locked1}, 1);
    chk("sat_err_start", {24'd0, err_cnt1}, 0);
    for (int i = 0; i < 100; i++) drive(1'b1, din1 + 8'd2, 4);
    chk("sat_err_100", {24'd0, err_cnt1}, 100);
    for (int i = 0; i < 200; i++) drive(1'b1, din1 + 8'd2, 4);
    chk("sat_err_full", {24'd0, err_cnt1}, 32'hFF);
    chk("sat_still_locked", {31'd0, locked1}, 1);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
